clock_sequencer: RTL and testbench
==================================

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

Interface
REQ-001 Parameter SHORT_LEN, default 12: length of a short machine cycle, in clk ticks.
REQ-002 Parameter LONG_LEN, default 16: length of a long machine cycle, in clk ticks.
REQ-003 Parameter TAP_STEP, default 2: spacing between successive taps, in clk ticks.
REQ-004 clk  in  1  the single clock; the tick reference, 10 ns nominal.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 start  in  1  request to begin a machine cycle; level-sampled.
REQ-007 long_cycle  in  1  selects LONG_LEN for the cycle being started; sampled only at cycle begin.
REQ-008 hold  in  1  wait request; freezes cycle progress while high.
REQ-009 tap  out  5  delay-line-equivalent outputs; tap[i] nominally corresponds to a (i+1)*20 ns delay.
REQ-010 tpclk  out  1  machine clock phase; high during the first half of the cycle.
REQ-011 tpwp  out  1  write pulse, 2 ticks wide, near the end of the cycle.
REQ-012 busy  out  1  high while a cycle is in progress.
REQ-013 done  out  1  one-tick pulse on the final tick of a cycle.

Function
REQ-014 The block SHALL have exactly two states: IDLE and RUN. It SHALL contain a 4-bit tick counter cnt and a registered cycle length len_q.
REQ-015 In IDLE with start=1, at the next clk edge the block SHALL enter RUN, set cnt=0, and set len_q to LONG_LEN if long_cycle=1, otherwise to SHORT_LEN.
REQ-016 In RUN with hold=0, cnt SHALL increment by 1 per clk.
REQ-017 In RUN with hold=1, cnt, state and len_q SHALL hold, and all outputs SHALL keep their current values.
REQ-018 The final tick is RUN with cnt=len_q-1 and hold=0. On the final tick:
- with start=1, the next edge SHALL begin a new cycle (cnt=0, len_q resampled), with no IDLE tick in between;
- with start=0, the next edge SHALL return the block to IDLE.
REQ-019 start asserted in RUN other than on the final tick SHALL be ignored; it is not queued. long_cycle changes during RUN SHALL NOT affect len_q.
REQ-020 Outputs SHALL be combinational decodes of state, cnt and len_q only, with no combinational path from any input:
- tap[i] = RUN and cnt >= (i+1)*TAP_STEP, for i = 0..4;
- tpclk = RUN and cnt < len_q/2 (integer division);
- tpwp = RUN and (cnt = len_q-4 or cnt = len_q-3);
- busy = RUN;
- done = RUN and cnt = len_q-1.
REQ-021 done SHALL be high for exactly one tick per completed cycle; while hold=1 on the final tick, done SHALL remain high until hold is released.
REQ-022 In IDLE, all outputs SHALL be 0.
REQ-023 Parameter legality: 5*TAP_STEP < SHORT_LEN; SHORT_LEN <= LONG_LEN <= 16; SHORT_LEN >= 6. Illegal values SHALL be flagged at elaboration, by a simulation-only check.

Reset
REQ-024 With reset_n=0 at a clk edge, the block SHALL enter IDLE with cnt=0 and len_q=SHORT_LEN, regardless of start, hold or the current state.
REQ-025 Reset mid-cycle SHALL abort the cycle: no done pulse, and all outputs 0 from the edge onward.
REQ-026 After reset_n returns to 1, a start SHALL be honoured on the first edge it is sampled.

Verification
REQ-027 Short cycle: start=1 for 1 tick, long_cycle=0, hold=0. Required response:
- busy high for 12 ticks;
- tap[0..4] rise at cnt 2, 4, 6, 8, 10;
- tpclk high for cnt 0..5;
- tpwp high for cnt 8..9;
- done at cnt 11, then IDLE.
REQ-028 Long cycle: long_cycle=1 at start. Required response: busy 16 ticks, tpclk high for cnt 0..7, tpwp high for cnt 12..13, done at cnt 15. Toggling long_cycle mid-cycle SHALL have no effect.
REQ-029 Back-to-back: start held high for 3 short cycles. Required response: busy continuously high for 36 ticks, done at ticks 11, 23 and 35, cnt returns to 0 immediately after each done.
REQ-030 Hold: hold=1 for 5 ticks at cnt=4, then hold=1 for 3 ticks at cnt=11. Required response:
- outputs frozen during the first hold;
- done high for 4 ticks during the second hold (3 held ticks plus the released tick);
- total busy = 20 ticks.
REQ-031 Reset mid-operation: reset_n=0 at cnt=7 of a long cycle. Required response: all outputs 0 at the next edge, no done pulse. start at the first edge after release begins a fresh cycle with cnt=0.
REQ-032 Ignored start: start pulsed at cnt=3 of a short cycle. Required response: the cycle completes normally at 12 ticks, then IDLE, with no second cycle.

Source files
------------

// File: rtl/clock_sequencer.sv
// clock_sequencer: generates machine-cycle timing phases, taps and a write pulse
// from a single clock, replacing a tapped delay line with a tick counter.
module clock_sequencer #(
   parameter int unsigned SHORT_LEN = 12,
   parameter int unsigned LONG_LEN  = 16,
   parameter int unsigned TAP_STEP  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       long_cycle,
   input  logic       hold,
   output logic [4:0] tap,
   output logic       tpclk,
   output logic       tpwp,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned LEN_W    = 5;
   localparam int unsigned NUM_TAPS = 5;

   // Reject parameter sets whose taps, write pulse or counter would not fit the cycle
   if ((NUM_TAPS * TAP_STEP >= SHORT_LEN) || (SHORT_LEN > LONG_LEN) ||
       (LONG_LEN > 16) || (SHORT_LEN < 6)) begin : g_param_check
      $error("clock_sequencer: illegal SHORT_LEN/LONG_LEN/TAP_STEP combination");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;

   logic [LEN_W-1:0]   cnt_ext;
   logic [LEN_W-1:0]   last_cnt;
   logic [LEN_W-1:0]   start_len;
   logic               run;
   logic               at_last;

   // Shared decode terms; cnt is widened so it compares directly against len_q
   assign run       = (state_q == RUN);
   assign cnt_ext   = LEN_W'(cnt_q);
   assign last_cnt  = len_q - LEN_W'(1);
   assign at_last   = (cnt_ext == last_cnt);
   assign start_len = long_cycle ? LEN_W'(LONG_LEN) : LEN_W'(SHORT_LEN);

   // Next-state logic: hold freezes everything in RUN, the final tick may chain a new cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               len_d   = start_len;
            end
         end
         RUN: begin
            if (!hold) begin
               if (at_last) begin
                  cnt_d = '0;
                  if (start) begin
                     len_d = start_len;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
      endcase
   end

   // State, counter and cycle-length registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= LEN_W'(SHORT_LEN);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Each tap goes high once the counter passes its delay-line equivalent position
   for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
      assign tap[i] = run && (cnt_ext >= LEN_W'((i + 1) * TAP_STEP));
   end

   // Phase outputs decode only registered state, so inputs never reach them combinationally
   assign tpclk = run && (cnt_ext < (len_q >> 1));
   assign tpwp  = run && ((cnt_ext == len_q - LEN_W'(4)) || (cnt_ext == len_q - LEN_W'(3)));
   assign busy  = run;
   assign done  = run && at_last;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: directed scenarios push per-tick expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_clock_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       long_cycle;
   logic       hold;
   logic [4:0] tap;
   logic       tpclk;
   logic       tpwp;
   logic       busy;
   logic       done;

   typedef struct {
      string      nm;
      logic [8:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   busy_seen = 0;
   int   done_seen = 0;

   clock_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .long_cycle (long_cycle),
      .hold       (hold),
      .tap        (tap),
      .tpclk      (tpclk),
      .tpwp       (tpwp),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Expected {tap[4:0], tpclk, tpwp, busy, done} for the default parameters
   function automatic logic [8:0] expv(input bit run, input int cnt, input int len);
      logic [4:0] t;
      if (!run) return 9'd0;
      for (int i = 0; i < 5; i++) t[i] = (cnt >= 2 * (i + 1));
      return {t, (cnt < len / 2), ((cnt == len - 4) || (cnt == len - 3)), 1'b1, (cnt == len - 1)};
   endfunction

   // Push the expectation for the current tick, apply inputs for the next edge
   task automatic step(input bit s, input bit lc, input bit h, input bit rn,
                       input bit run, input int cnt, input int len, input string nm);
      exp_t e;
      e.nm = nm;
      e.v  = expv(run, cnt, len);
      sb_q.push_back(e);
      start      = s;
      long_cycle = lc;
      hold       = h;
      reset_n    = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      exp_t       e;
      logic [8:0] got;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         got = {tap, tpclk, tpwp, busy, done};
         checks++;
         if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %b want %b (tap,tpclk,tpwp,busy,done)", e.nm, got, e.v);
         end
         if (busy === 1'b1) busy_seen++;
         if (done === 1'b1) done_seen++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      int b0, d0;
      reset_n    = 1'b0;
      start      = 1'b0;
      long_cycle = 1'b0;
      hold       = 1'b0;
      @(posedge clk);
      #1;

      // Reset dominates start and hold
      step(1, 1, 1, 0, 0, 0, 12, "reset_with_start_hold");
      step(0, 0, 0, 1, 0, 0, 12, "reset_idle");
      step(0, 0, 0, 1, 0, 0, 12, "idle_no_start");

      // Short cycle
      b0 = busy_seen; d0 = done_seen;
      step(1, 0, 0, 1, 0, 0, 12, "short_launch");
      for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 1, c, 12, $sformatf("short_c%0d", c));
      step(0, 0, 0, 1, 0, 0, 12, "short_end_idle");
      check_int("short_busy_ticks", busy_seen - b0, 12);
      check_int("short_done_ticks", done_seen - d0, 1);

      // Long cycle, long_cycle toggled mid-cycle
      b0 = busy_seen; d0 = done_seen;
      step(1, 1, 0, 1, 0, 0, 16, "long_launch");
      for (int c = 0; c < 16; c++) step(0, c[0], 0, 1, 1, c, 16, $sformatf("long_c%0d", c));
      step(0, 0, 0, 1, 0, 0, 16, "long_end_idle");
      check_int("long_busy_ticks", busy_seen - b0, 16);
      check_int("long_done_ticks", done_seen - d0, 1);

      // Back-to-back: start held through three short cycles
      b0 = busy_seen; d0 = done_seen;
      step(1, 0, 0, 1, 0, 0, 12, "b2b_launch");
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 12; c++)
            step(!(k == 2 && c == 11), 0, 0, 1, 1, c, 12, $sformatf("b2b_k%0d_c%0d", k, c));
      step(0, 0, 0, 1, 0, 0, 12, "b2b_end_idle");
      check_int("b2b_busy_ticks", busy_seen - b0, 36);
      check_int("b2b_done_ticks", done_seen - d0, 3);

      // Hold 5 ticks at cnt 4, 3 ticks at cnt 11
      b0 = busy_seen; d0 = done_seen;
      step(1, 0, 0, 1, 0, 0, 12, "hold_launch");
      for (int c = 0; c < 12; c++) begin
         int reps;
         reps = (c == 4) ? 6 : ((c == 11) ? 4 : 1);
         for (int r = 0; r < reps; r++)
            step(0, 0, (r < reps - 1), 1, 1, c, 12, $sformatf("hold_c%0d_r%0d", c, r));
      end
      step(0, 0, 0, 1, 0, 0, 12, "hold_end_idle");
      check_int("hold_busy_ticks", busy_seen - b0, 20);
      check_int("hold_done_ticks", done_seen - d0, 4);

      // Reset at cnt 7 of a long cycle, then immediate restart
      d0 = done_seen;
      step(1, 1, 0, 1, 0, 0, 16, "rst_launch");
      for (int c = 0; c < 7; c++) step(0, 1, 0, 1, 1, c, 16, $sformatf("rst_c%0d", c));
      step(1, 1, 1, 0, 1, 7, 16, "rst_assert_c7");
      step(1, 0, 0, 1, 0, 0, 12, "rst_aborted_idle");
      check_int("rst_no_done", done_seen - d0, 0);
      for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 1, c, 12, $sformatf("rst_fresh_c%0d", c));
      step(0, 0, 0, 1, 0, 0, 12, "rst_fresh_idle");
      check_int("rst_fresh_done", done_seen - d0, 1);

      // Start pulsed mid-cycle is not queued
      b0 = busy_seen;
      step(1, 0, 0, 1, 0, 0, 12, "ign_launch");
      for (int c = 0; c < 12; c++) step((c == 3), 1, 0, 1, 1, c, 12, $sformatf("ign_c%0d", c));
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 12, $sformatf("ign_idle%0d", i));
      check_int("ign_busy_ticks", busy_seen - b0, 12);

      check_int("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
